// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve pacing, miss-to-score conversion and match end detection.
// All outputs come from registers or a decode of the registered state.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE   = 9,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned POINT_HOLD  = 30
) (
  input  logic       PixelClock,
  input  logic       nReset,
  input  logic       frameTick,
  input  logic       serveBtn,
  input  logic       missLeft,
  input  logic       missRight,
  output logic       ballReset,
  output logic       ballRun,
  output logic       serveDir,
  output logic [3:0] scoreLeft,
  output logic [3:0] scoreRight,
  output logic       gameOver,
  output logic [2:0] state
);

  localparam logic [3:0] WIN = 4'(WIN_SCORE);
  localparam logic [7:0] SD  = 8'(SERVE_DELAY);
  localparam logic [7:0] PH  = 8'(POINT_HOLD);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sbtn_q;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       dir_q, dir_d;

  logic       serve_rise;
  logic [7:0] cnt_inc;

  assign serve_rise = serveBtn & ~sbtn_q;
  assign cnt_inc    = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    score_l_d = score_l_q;
    score_r_d = score_r_q;
    dir_d     = dir_q;
    case (state_q)
      S_IDLE: begin
        if (serve_rise) state_d = S_SERVE;
      end
      S_SERVE: begin
        if (frameTick && cnt_inc == SD) state_d = S_PLAY;
      end
      S_PLAY: begin
        // A simultaneous double miss ends the rally without awarding a point.
        if (missLeft && missRight) begin
          state_d = S_POINT;
        end else if (missLeft) begin
          if (score_r_q < WIN) score_r_d = score_r_q + 4'd1;
          dir_d   = 1'b0;
          state_d = S_POINT;
        end else if (missRight) begin
          if (score_l_q < WIN) score_l_d = score_l_q + 4'd1;
          dir_d   = 1'b1;
          state_d = S_POINT;
        end
      end
      S_POINT: begin
        if (frameTick && cnt_inc == PH)
          state_d = (score_l_q == WIN || score_r_q == WIN) ? S_OVER : S_SERVE;
      end
      S_OVER: begin
        if (serve_rise) begin
          state_d   = S_SERVE;
          score_l_d = 4'd0;
          score_r_d = 4'd0;
          dir_d     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Counter restarts on every state change, so a tick on the transition edge is dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) cnt_d = 8'd0;
    else if (frameTick)     cnt_d = cnt_inc;
  end

  always_ff @(posedge PixelClock or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      sbtn_q    <= 1'b0;
      score_l_q <= 4'd0;
      score_r_q <= 4'd0;
      dir_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sbtn_q    <= serveBtn;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      dir_q     <= dir_d;
    end
  end

  assign ballRun    = (state_q == S_PLAY);
  assign ballReset  = ~ballRun;
  assign gameOver   = (state_q == S_OVER);
  assign serveDir   = dir_q;
  assign scoreLeft  = score_l_q;
  assign scoreRight = score_r_q;
  assign state      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed and randomized check of pong_match_ctrl against a cycle-level rule model.
module tb_pong_match_ctrl;

  localparam int W  = 2;
  localparam int SD = 3;
  localparam int PH = 2;

  logic       PixelClock = 1'b0;
  logic       nReset = 1'b0;
  logic       frameTick = 1'b0, serveBtn = 1'b0, missLeft = 1'b0, missRight = 1'b0;
  logic       ballReset, ballRun, serveDir, gameOver;
  logic [3:0] scoreLeft, scoreRight;
  logic [2:0] state;

  int tests = 0;
  int fails = 0;

  // model: phase 0 idle, 1 serving, 2 rally, 3 point, 4 over
  int m_phase, m_ticks, m_left, m_right, m_dir, m_btn;

  pong_match_ctrl #(.WIN_SCORE(W), .SERVE_DELAY(SD), .POINT_HOLD(PH)) dut (
    .PixelClock(PixelClock), .nReset(nReset), .frameTick(frameTick),
    .serveBtn(serveBtn), .missLeft(missLeft), .missRight(missRight),
    .ballReset(ballReset), .ballRun(ballRun), .serveDir(serveDir),
    .scoreLeft(scoreLeft), .scoreRight(scoreRight), .gameOver(gameOver),
    .state(state)
  );

  always #5 PixelClock = ~PixelClock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".state"},     8'(state),      8'(m_phase));
    check({tag, ".scoreL"},    8'(scoreLeft),  8'(m_left));
    check({tag, ".scoreR"},    8'(scoreRight), 8'(m_right));
    check({tag, ".serveDir"},  8'(serveDir),   8'(m_dir));
    check({tag, ".ballRun"},   8'(ballRun),    8'(m_phase == 2));
    check({tag, ".ballReset"}, 8'(ballReset),  8'(m_phase != 2));
    check({tag, ".gameOver"},  8'(gameOver),   8'(m_phase == 4));
  endtask

  task automatic model_reset();
    m_phase = 0; m_ticks = 0; m_left = 0; m_right = 0; m_dir = 1; m_btn = 0;
  endtask

  // Rules applied to one clock edge with the given inputs.
  task automatic model_edge(input int ft, input int sb, input int ml, input int mr);
    int nxt;
    bit rise;
    rise = (sb != 0) && (m_btn == 0);
    nxt  = m_phase;
    if (m_phase == 0 && rise) nxt = 1;
    else if (m_phase == 1 && ft != 0 && m_ticks + 1 == SD) nxt = 2;
    else if (m_phase == 2 && (ml != 0 || mr != 0)) begin
      nxt = 3;
      if (ml != 0 && mr == 0) begin m_right = (m_right + 1 > W) ? W : m_right + 1; m_dir = 0; end
      if (mr != 0 && ml == 0) begin m_left  = (m_left  + 1 > W) ? W : m_left  + 1; m_dir = 1; end
    end
    else if (m_phase == 3 && ft != 0 && m_ticks + 1 == PH)
      nxt = (m_left == W || m_right == W) ? 4 : 1;
    else if (m_phase == 4 && rise) begin
      nxt = 1; m_left = 0; m_right = 0; m_dir = 1;
    end
    if (nxt != m_phase) m_ticks = 0;
    else if (ft != 0)   m_ticks = (m_ticks + 1) % 256;
    m_phase = nxt;
    m_btn   = sb;
  endtask

  // One clock cycle: drive, advance model, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input int ft, input int sb, input int ml, input int mr);
    frameTick = 1'(ft); serveBtn = 1'(sb); missLeft = 1'(ml); missRight = 1'(mr);
    model_edge(ft, sb, ml, mr);
    @(posedge PixelClock); #1;
    check_all(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(tag, 0, 0, 0, 0);
      cyc(tag, 1, 0, 0, 0);
    end
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    @(posedge PixelClock); #1;
    nReset = 1'b1;
    cyc("idle", 0, 0, 0, 0);

    // serveBtn held high across 10 cycles gives a single transition
    for (int i = 0; i < 10; i++) cyc("hold_btn", 0, 1, 0, 0);
    check("hold_btn.in_serve", 8'(state), 8'd1);
    cyc("btn_low", 0, 0, 0, 0);

    // two ticks leave the ball parked, the third releases it
    ticks("serve_t12", 2);
    check("serve.not_run", 8'(ballRun), 8'd0);
    cyc("serve_gap", 0, 0, 0, 0);
    cyc("serve_t3", 1, 0, 0, 0);
    check("serve.run", 8'(ballRun), 8'd1);

    cyc("miss_right", 0, 0, 0, 1);
    check("miss_right.scoreL", 8'(scoreLeft), 8'd1);
    cyc("point_missL", 0, 0, 1, 0);
    ticks("point_hold", 2);
    check("point_done", 8'(state), 8'd1);
    cyc("serve_missL", 0, 0, 1, 0);
    ticks("serve2", 3);

    cyc("double_miss", 0, 0, 1, 1);
    check("double_miss.state", 8'(state), 8'd3);
    ticks("point2", 2);
    ticks("serve3", 3);

    cyc("miss_left1", 0, 0, 1, 0);
    ticks("point3", 2);
    ticks("serve4", 3);
    cyc("miss_left2", 0, 0, 1, 0);
    check("win.scoreR", 8'(scoreRight), 8'd2);
    ticks("point4", 2);
    check("over.state", 8'(state), 8'd4);
    cyc("over_missL", 0, 0, 1, 0);
    cyc("over_missR", 1, 0, 0, 1);
    ticks("over_ticks", 3);
    cyc("over_rise", 0, 1, 0, 0);
    check("restart.scoreR", 8'(scoreRight), 8'd0);
    cyc("over_rel", 0, 0, 0, 0);

    // reach a live rally, then reset between edges
    ticks("serve5", 3);
    cyc("miss_right2", 0, 0, 0, 1);
    ticks("point5", 2);
    ticks("serve6", 3);
    check("pre_reset.run", 8'(ballRun), 8'd1);
    #2 nReset = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #2 nReset = 1'b1;
    @(posedge PixelClock); #1;
    check_all("post_reset");

    for (int i = 0; i < 1500; i++) begin
      int ft, sb, ml, mr;
      ft = ($urandom_range(0, 2) == 0) ? 1 : 0;
      sb = ($urandom_range(0, 5) == 0) ? 1 : 0;
      ml = ($urandom_range(0, 7) == 0) ? 1 : 0;
      mr = ($urandom_range(0, 7) == 0) ? 1 : 0;
      cyc("random", ft, sb, ml, mr);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
